// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the SPORK data memory controller.
package dmem_pkg;

   localparam int unsigned DMEM_DATA_W = 8;
   localparam int unsigned DMEM_ADDR_W = 8;

   // Controller phases: sweep memory to zero after reset, then serve requests.
   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } dmem_state_t;

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// Word storage with one write port and a registered, write-first read port.
// With DMEM_PARITY_EN defined, an even-parity bit is stored per word and checked on read.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = DMEM_DATA_W,
   parameter int unsigned ADDR_W = DMEM_ADDR_W,
   parameter int unsigned DEPTH  = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic              rd_zero_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
`ifdef DMEM_PARITY_EN
   output logic              rd_perr_o,
`endif
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              fwd_c;

   // Same-edge write to the address being read: the read sees the new data.
   assign fwd_c = wr_en_i && (wr_addr_i == rd_addr_i);

   // Storage write port; contents are defined only by writes (no reset).
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Read data selection: forced zero, forwarded write data, or stored word.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en_i) begin
         if (rd_zero_i) begin
            rd_data_d = '0;
         end else if (fwd_c) begin
            rd_data_d = wr_data_i;
         end else begin
            rd_data_d = mem_q[rd_addr_i];
         end
      end
   end

   // Read data register; holds its value between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data_o = rd_data_q;

`ifdef DMEM_PARITY_EN
   logic par_q [DEPTH];
   logic perr_q, perr_d;

   // Parity bit written alongside each data word.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         par_q[wr_addr_i] <= ^wr_data_i;
      end
   end

   // Parity mismatch only possible when the stored word is actually returned.
   always_comb begin
      perr_d = 1'b0;
      if (rd_en_i && !rd_zero_i && !fwd_c) begin
         perr_d = par_q[rd_addr_i] != (^mem_q[rd_addr_i]);
      end
   end

   // Parity error pulse register, aligned with the read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end

   assign rd_perr_o = perr_q;
`endif

endmodule : dmem_array

// File: rtl/data_memory_ctrl.sv
// SPORK data memory controller: post-reset clear sweep, request qualification,
// address range check and registered read/status outputs.
// Optional feature macro: DMEM_PARITY_EN (per-word parity, ParityErr output).
module data_memory_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = DMEM_DATA_W,
   parameter int unsigned ADDR_W = DMEM_ADDR_W,
   parameter int unsigned DEPTH  = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ReadMem,
   input  logic              WriteMem,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] DataIn,
   output logic [DATA_W-1:0] DataOut,
   output logic              ReadValid,
   output logic              Ready,
`ifdef DMEM_PARITY_EN
   output logic              ParityErr,
`endif
   output logic              AddrErr
);

   localparam int unsigned       FULL_DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);

   dmem_state_t       state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              valid_q, valid_d;
   logic              addr_err_q, addr_err_d;
   logic              ready_q;
   logic              in_range_c;
   logic              arr_we_c;
   logic [ADDR_W-1:0] arr_waddr_c;
   logic [DATA_W-1:0] arr_wdata_c;
   logic              arr_re_c;

   // Range check collapses to constant true when every address is implemented.
   generate
      if (DEPTH >= FULL_DEPTH) begin : g_full_range
         assign in_range_c = 1'b1;
      end else begin : g_part_range
         assign in_range_c = 32'(data_addr) < DEPTH;
      end
   endgenerate

   // State, clear counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_CLEAR;
         clr_cnt_q  <= '0;
         valid_q    <= 1'b0;
         addr_err_q <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         valid_q    <= valid_d;
         addr_err_q <= addr_err_d;
         ready_q    <= state_d == ST_IDLE;
      end
   end

   // Next state, clear sweep and request qualification.
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      arr_we_c    = 1'b0;
      arr_waddr_c = data_addr;
      arr_wdata_c = DataIn;
      arr_re_c    = 1'b0;
      valid_d     = 1'b0;
      addr_err_d  = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            arr_we_c    = 1'b1;
            arr_waddr_c = clr_cnt_q;
            arr_wdata_c = '0;
            clr_cnt_d   = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == LAST_IDX) begin
               state_d   = ST_IDLE;
               clr_cnt_d = '0;
            end
         end
         ST_IDLE: begin
            arr_we_c   = WriteMem && in_range_c;
            arr_re_c   = ReadMem;
            valid_d    = ReadMem;
            addr_err_d = (ReadMem || WriteMem) && !in_range_c;
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (arr_we_c),
      .wr_addr_i (arr_waddr_c),
      .wr_data_i (arr_wdata_c),
      .rd_en_i   (arr_re_c),
      .rd_zero_i (!in_range_c),
      .rd_addr_i (data_addr),
`ifdef DMEM_PARITY_EN
      .rd_perr_o (ParityErr),
`endif
      .rd_data_o (DataOut)
   );

   assign ReadValid = valid_q;
   assign AddrErr   = addr_err_q;
   assign Ready     = ready_q;

endmodule : data_memory_ctrl
